// File: rtl/vga_scan_if.sv
// vga_scan_if: pixel-RAM read port plus VGA video outputs of the scan stage.
// The master side is the scan stage; the slave side is the RAM and display.
interface vga_scan_if;
  logic [11:0] din;
  logic [6:0]  col_addr;
  logic [5:0]  row_addr;
  logic        rdn;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        frame_pulse;

  modport master (
    input  din,
    output col_addr, row_addr, rdn, hs, vs, r, g, b, frame_pulse
  );

  modport slave (
    output din,
    input  col_addr, row_addr, rdn, hs, vs, r, g, b, frame_pulse
  );
endinterface

// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 VGA timing, block-granular pixel-RAM addressing, 2-stage aligned output.
// Define VGA_TEST_PATTERN_EN to replace RAM colour with 128-px vertical colour bars.
module vga_scan #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  vga_scan_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;
  logic        frame_start;

  logic        active_d;
  logic        hs_d;
  logic        vs_d;
  logic        frame_d;

  logic [11:0] pix;
  logic [11:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        frame_q;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // which is what makes the two pipeline stages line up cycle-exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw      = ~((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_raw      = ~((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign frame_start = (h_cnt == 10'd0) && (v_cnt == V_ACT);

  // Addresses track the counters even in blanking; the RAM ignores them while rdn is high.
  assign bus.col_addr = h_cnt[9:3];
  assign bus.row_addr = v_cnt[8:3];
  assign bus.rdn      = ~active;

  // Stage 1: delay timing by the RAM's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_d <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
      frame_d  <= 1'b0;
    end else begin
      active_d <= active;
      hs_d     <= hs_raw;
      vs_d     <= vs_raw;
      frame_d  <= frame_start;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bar_d <= '0;
    else     bar_d <= h_cnt[9:7];
  end

  assign pix = {{4{bar_d[2]}}, {4{bar_d[1]}}, {4{bar_d[0]}}};
`else
  assign pix = bus.din;
`endif

  // Stage 2: colour blanked outside the visible area, sync aligned with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      rgb_q   <= active_d ? pix : 12'h000;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      frame_q <= frame_d;
    end
  end

  assign bus.r           = rgb_q[11:8];
  assign bus.g           = rgb_q[7:4];
  assign bus.b           = rgb_q[3:0];
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.frame_pulse = frame_q;

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed checks of vga_scan line/frame timing, colour path and reset,
// using full horizontal timing and a shortened 22-line frame (16 visible lines).
module tb_vga_scan;

  localparam int V_VIS   = 16;
  localparam int FRAME   = 22 * 800;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] EXP_X17  = 12'h000;
  localparam logic [11:0] EXP_X130 = 12'h00F;
  localparam logic [11:0] EXP_X639 = 12'hF00;
  localparam logic [11:0] EXP_L0   = 12'h000;
`else
  localparam logic [11:0] EXP_X17  = 12'h21A;
  localparam logic [11:0] EXP_X130 = 12'h01A;
  localparam logic [11:0] EXP_X639 = 12'hF1A;
  localparam logic [11:0] EXP_L0   = 12'h20A;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n;
  int   total = 0;
  int   bad   = 0;

  vga_scan_if bus ();

  vga_scan #(
    .V_VISIBLE (V_VIS),
    .V_FP      (2),
    .V_SYNC    (2),
    .V_BP      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM whose word encodes the block address it was read from.
  always @(posedge clk) bus.din <= {bus.col_addr[3:0], bus.row_addr[3:0], 4'hA};

  // Clock edges since reset release; at the following negedge outputs show pixel n-2.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int target);
    int guard = 0;
    while (n != target) begin
      @(negedge clk);
      guard++;
      if (guard > 60000) begin
        total++;
        bad++;
        $display("FAIL wait_n: observed n=%0d expected n=%0d", n, target);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
      end
    end
  endtask

  function automatic logic [11:0] rgb();
    return {bus.r, bus.g, bus.b};
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_hs"},   bus.hs, 1'b1);
    check({pfx, "_vs"},   bus.vs, 1'b1);
    check({pfx, "_rgb"},  rgb(), 12'h000);
    check({pfx, "_fp"},   bus.frame_pulse, 1'b0);
    check({pfx, "_rdn"},  bus.rdn, 1'b0);
    check({pfx, "_col"},  bus.col_addr, 7'd0);
    check({pfx, "_row"},  bus.row_addr, 6'd0);
  endtask

  initial begin
    int rdn_low, hs_low, vs_low, fp_cnt, fp_at;

    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Counter progress seen through the column address.
    wait_n(1);   check("hs_pre_first",  bus.hs, 1'b1);
    wait_n(8);   check("col_at_8",      bus.col_addr, 7'd1);
    wait_n(657); check("hs_before_fall", bus.hs, 1'b1);
    wait_n(658); check("hs_fall",        bus.hs, 1'b0);
    wait_n(753); check("hs_last_low",    bus.hs, 1'b0);
    wait_n(754); check("hs_rise",        bus.hs, 1'b1);
    wait_n(799); check("col_at_799",     bus.col_addr, 7'd99);
                 check("rdn_at_799",     bus.rdn, 1'b1);
    wait_n(800); check("col_wrap",       bus.col_addr, 7'd0);
                 check("rdn_wrap",       bus.rdn, 1'b0);

    // One full counter line for rdn, overlapping output line 1's sync pulse.
    rdn_low = 0;
    hs_low  = 0;
    for (int i = 0; i < 800; i++) begin
      wait_n(800 + i);
      if (bus.rdn == 1'b0) rdn_low++;
      if (bus.hs == 1'b0)  hs_low++;
    end
    check("rdn_low_per_line", rdn_low, 640);
    check("hs_low_per_line",  hs_low, 96);

    // Colour path on line 9.
    wait_n(9 * 800 + 17 + 2);  check("pix_17_9",  rgb(), EXP_X17);
    wait_n(9 * 800 + 130 + 2); check("pix_130_9", rgb(), EXP_X130);
    wait_n(9 * 800 + 639 + 2); check("pix_639_9", rgb(), EXP_X639);
    wait_n(9 * 800 + 640 + 2); check("pix_640_9", rgb(), 12'h000);
                               check("hs_640_9",  bus.hs, 1'b1);

    // Frame pulse at the first output clock of line V_VIS, vsync over lines 18..19.
    wait_n(V_VIS * 800 + 1); check("fp_before", bus.frame_pulse, 1'b0);
    wait_n(V_VIS * 800 + 2); check("fp_on",     bus.frame_pulse, 1'b1);
                             check("fp_rgb",    rgb(), 12'h000);
    wait_n(V_VIS * 800 + 3); check("fp_after",  bus.frame_pulse, 1'b0);
    wait_n(18 * 800 + 1);    check("vs_before", bus.vs, 1'b1);
    wait_n(18 * 800 + 2);    check("vs_fall",   bus.vs, 1'b0);
    wait_n(20 * 800 + 1);    check("vs_last",   bus.vs, 1'b0);
    wait_n(20 * 800 + 2);    check("vs_rise",   bus.vs, 1'b1);

    // Simultaneous wrap of both counters at (799, last line).
    wait_n(FRAME - 1); check("col_h799_vlast", bus.col_addr, 7'd99);
                       check("row_h799_vlast", bus.row_addr, 6'd2);
    wait_n(FRAME);     check("col_frame_wrap", bus.col_addr, 7'd0);
                       check("row_frame_wrap", bus.row_addr, 6'd0);
                       check("rdn_frame_wrap", bus.rdn, 1'b0);

    // Whole second frame at the outputs.
    vs_low = 0;
    fp_cnt = 0;
    fp_at  = -1;
    for (int i = 0; i < FRAME; i++) begin
      wait_n(FRAME + 2 + i);
      if (bus.vs == 1'b0) vs_low++;
      if (bus.frame_pulse) begin
        fp_cnt++;
        fp_at = n;
      end
    end
    check("vs_low_per_frame", vs_low, 1600);
    check("fp_per_frame",     fp_cnt, 1);
    check("fp_position",      fp_at, FRAME + V_VIS * 800 + 2);

    // Asynchronous reset at h=300, v=10 of the third frame.
    wait_n(2 * FRAME + 10 * 800 + 300);
    check("pre_rst_col", bus.col_addr, 7'd37);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    wait_n(19);  check("rst_pix_17_0", rgb(), EXP_L0);
    wait_n(657); check("rst_hs_before", bus.hs, 1'b1);
    wait_n(658); check("rst_hs_fall",   bus.hs, 1'b0);
    wait_n(799); check("rst_col_799",   bus.col_addr, 7'd99);
    wait_n(800); check("rst_col_wrap",  bus.col_addr, 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
